// File: rtl/bfpu_pkg.sv
// bfpu_pkg: shared opcode, state and error-code definitions for the BFPU core.
package bfpu_pkg;

  localparam int unsigned OP_WIDTH  = 3;
  localparam int unsigned ERR_WIDTH = 2;

  localparam logic [OP_WIDTH-1:0] OP_RIGHT      = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_LEFT       = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_INC        = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_DEC        = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_OUT        = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_IN         = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_LOOP_BEGIN = 3'd6;
  localparam logic [OP_WIDTH-1:0] OP_LOOP_END   = 3'd7;

  localparam logic [ERR_WIDTH-1:0] ERR_NONE            = 2'd0;
  localparam logic [ERR_WIDTH-1:0] ERR_OVF             = 2'd1;
  localparam logic [ERR_WIDTH-1:0] ERR_UNMATCHED_CLOSE = 2'd2;
  localparam logic [ERR_WIDTH-1:0] ERR_UNMATCHED_OPEN  = 2'd3;

  typedef enum logic [3:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_SKIP,
    ST_OUT_WAIT,
    ST_IN_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/bfpu_loop_stack.sv
// bfpu_loop_stack: LIFO of '[' return addresses with synchronous clear.
module bfpu_loop_stack #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned PC_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                i_clear,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [PC_WIDTH-1:0] i_data,
  output logic [PC_WIDTH-1:0] o_top_c,
  output logic                o_empty_c,
  output logic                o_full_c
);
  localparam int unsigned SP_WIDTH  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0]  r_mem [STACK_DEPTH];
  logic [SP_WIDTH-1:0]  r_sp;
  logic [IDX_WIDTH-1:0] w_top_idx;
  logic [IDX_WIDTH-1:0] w_wr_idx;

  assign w_top_idx = IDX_WIDTH'(r_sp - SP_WIDTH'(1));
  assign w_wr_idx  = IDX_WIDTH'(r_sp);
  assign o_top_c   = r_mem[w_top_idx];
  assign o_empty_c = (r_sp == '0);
  assign o_full_c  = (r_sp == SP_WIDTH'(STACK_DEPTH));

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_sp <= '0;
    end else if (i_push && !o_full_c) begin
      r_sp <= r_sp + SP_WIDTH'(1);
    end else if (i_pop && !o_empty_c) begin
      r_sp <= r_sp - SP_WIDTH'(1);
    end
  end

  // Storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (!i_clear && i_push && !o_full_c) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/bfpu_core.sv
// bfpu_core: Brainfuck execution core with internal tape, bracket stack and valid/ready byte I/O.
// Define BFPU_SATURATE_EN to make '+'/'-' saturate instead of wrapping.
module bfpu_core
  import bfpu_pkg::*;
#(
  parameter int unsigned CELL_WIDTH  = 8,
  parameter int unsigned TAPE_DEPTH  = 16,
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [PC_WIDTH-1:0]   prog_addr,
  input  logic [OP_WIDTH-1:0]   prog_instr,
  input  logic                  prog_end,
  input  logic [CELL_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CELL_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ERR_WIDTH-1:0]  err_code
);
  localparam int unsigned PTR_WIDTH = $clog2(TAPE_DEPTH);

  state_t                r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]   r_pc, w_pc_nxt;
  logic [PTR_WIDTH-1:0]  r_ptr, w_ptr_nxt;
  logic [PTR_WIDTH-1:0]  r_clr_idx, w_clr_idx_nxt;
  logic [PC_WIDTH-1:0]   r_skip_depth, w_skip_depth_nxt;
  logic                  r_skip_dec, w_skip_dec_nxt;
  logic [CELL_WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic                  r_in_ready, w_in_ready_nxt;
  logic [ERR_WIDTH-1:0]  r_err_code, w_err_code_nxt;
  logic                  r_busy, r_done, r_error;
  logic                  w_busy_nxt, w_done_nxt, w_error_nxt;

  logic [CELL_WIDTH-1:0] r_tape [TAPE_DEPTH];
  logic                  w_tape_we;
  logic [PTR_WIDTH-1:0]  w_tape_waddr;
  logic [CELL_WIDTH-1:0] w_tape_wdata;
  logic [CELL_WIDTH-1:0] w_cell, w_cell_inc, w_cell_dec;
  logic                  w_cell_nz;

  logic                  w_start_acc, w_push, w_pop;
  logic [PC_WIDTH-1:0]   w_stk_top;
  logic                  w_stk_empty, w_stk_full;

  assign w_cell    = r_tape[r_ptr];
  assign w_cell_nz = |w_cell;

`ifdef BFPU_SATURATE_EN
  assign w_cell_inc = (w_cell == '1) ? w_cell : w_cell + CELL_WIDTH'(1);
  assign w_cell_dec = (w_cell == '0) ? w_cell : w_cell - CELL_WIDTH'(1);
`else
  assign w_cell_inc = w_cell + CELL_WIDTH'(1);
  assign w_cell_dec = w_cell - CELL_WIDTH'(1);
`endif

  bfpu_loop_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_stack (
    .clk       (clk),
    .i_clear   (rst | w_start_acc),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (r_pc),
    .o_top_c   (w_stk_top),
    .o_empty_c (w_stk_empty),
    .o_full_c  (w_stk_full)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ptr_nxt        = r_ptr;
    w_clr_idx_nxt    = r_clr_idx;
    w_skip_depth_nxt = r_skip_depth;
    w_skip_dec_nxt   = r_skip_dec;
    w_out_data_nxt   = r_out_data;
    w_out_valid_nxt  = r_out_valid;
    w_in_ready_nxt   = r_in_ready;
    w_err_code_nxt   = r_err_code;
    w_tape_we        = 1'b0;
    w_tape_waddr     = r_ptr;
    w_tape_wdata     = w_cell;
    w_start_acc      = 1'b0;
    w_push           = 1'b0;
    w_pop            = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        w_tape_we     = 1'b1;
        w_tape_waddr  = r_clr_idx;
        w_tape_wdata  = '0;
        w_clr_idx_nxt = r_clr_idx + PTR_WIDTH'(1);
        if (r_clr_idx == PTR_WIDTH'(TAPE_DEPTH - 1)) w_state_nxt = ST_IDLE;
      end
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_start_acc    = 1'b1;
          w_pc_nxt       = '0;
          w_ptr_nxt      = '0;
          w_err_code_nxt = ERR_NONE;
          w_state_nxt    = ST_FETCH;
        end
      end
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (prog_end) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = r_pc + PC_WIDTH'(1);
          case (prog_instr)
            OP_RIGHT: w_ptr_nxt = r_ptr + PTR_WIDTH'(1);
            OP_LEFT:  w_ptr_nxt = r_ptr - PTR_WIDTH'(1);
            OP_INC: begin
              w_tape_we    = 1'b1;
              w_tape_wdata = w_cell_inc;
            end
            OP_DEC: begin
              w_tape_we    = 1'b1;
              w_tape_wdata = w_cell_dec;
            end
            OP_OUT: begin
              w_pc_nxt        = r_pc;
              w_out_data_nxt  = w_cell;
              w_out_valid_nxt = 1'b1;
              w_state_nxt     = ST_OUT_WAIT;
            end
            OP_IN: begin
              w_pc_nxt       = r_pc;
              w_in_ready_nxt = 1'b1;
              w_state_nxt    = ST_IN_WAIT;
            end
            OP_LOOP_BEGIN: begin
              if (!w_cell_nz) begin
                w_skip_depth_nxt = PC_WIDTH'(1);
                w_skip_dec_nxt   = 1'b0;
                w_state_nxt      = ST_SKIP;
              end else if (w_stk_full) begin
                w_err_code_nxt = ERR_OVF;
                w_state_nxt    = ST_ERROR;
              end else begin
                w_push = 1'b1;
              end
            end
            OP_LOOP_END: begin
              if (w_stk_empty) begin
                w_err_code_nxt = ERR_UNMATCHED_CLOSE;
                w_state_nxt    = ST_ERROR;
              end else if (w_cell_nz) begin
                w_pc_nxt = w_stk_top + PC_WIDTH'(1);
              end else begin
                w_pop = 1'b1;
              end
            end
          endcase
        end
      end
      // Alternates a fetch cycle (skip_dec=0) with a decode cycle.
      ST_SKIP: begin
        if (!r_skip_dec) begin
          w_skip_dec_nxt = 1'b1;
        end else if (prog_end) begin
          w_err_code_nxt = ERR_UNMATCHED_OPEN;
          w_state_nxt    = ST_ERROR;
        end else begin
          w_skip_dec_nxt = 1'b0;
          w_pc_nxt       = r_pc + PC_WIDTH'(1);
          if (prog_instr == OP_LOOP_BEGIN) begin
            w_skip_depth_nxt = r_skip_depth + PC_WIDTH'(1);
          end else if (prog_instr == OP_LOOP_END) begin
            w_skip_depth_nxt = r_skip_depth - PC_WIDTH'(1);
            if (r_skip_depth == PC_WIDTH'(1)) w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_OUT_WAIT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = r_pc + PC_WIDTH'(1);
          w_state_nxt     = ST_FETCH;
        end
      end
      ST_IN_WAIT: begin
        if (in_valid) begin
          w_tape_we      = 1'b1;
          w_tape_wdata   = in_data;
          w_in_ready_nxt = 1'b0;
          w_pc_nxt       = r_pc + PC_WIDTH'(1);
          w_state_nxt    = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase

    w_busy_nxt  = !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE) ||
                    (w_state_nxt == ST_ERROR));
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_error_nxt = (w_state_nxt == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      r_pc         <= '0;
      r_ptr        <= '0;
      r_clr_idx    <= '0;
      r_skip_depth <= '0;
      r_skip_dec   <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ptr        <= w_ptr_nxt;
      r_clr_idx    <= w_clr_idx_nxt;
      r_skip_depth <= w_skip_depth_nxt;
      r_skip_dec   <= w_skip_dec_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_err_code   <= w_err_code_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  // Tape has no reset; the CLEAR state zeroes it after every rst.
  always_ff @(posedge clk) begin
    if (!rst && w_tape_we) r_tape[w_tape_waddr] <= w_tape_wdata;
  end

  assign prog_addr = r_pc;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_bfpu_core.sv
// tb_bfpu_core: scoreboard bench for bfpu_core against a Brainfuck interpreter model.
module tb_bfpu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] prog_addr;
  logic [2:0] prog_instr;
  logic       prog_end;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  logic [2:0] mem [256];
  int         plen = 0;
  int         m_tape [16];
  logic [7:0] exp_q [$];
  logic [7:0] in_q [$];
  int         in_dly_min = 0;
  int         in_dly_max = 3;
  bit         hold_ready = 1'b0;

  always #5 clk = ~clk;

  bfpu_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_addr  (prog_addr),
    .prog_instr (prog_instr),
    .prog_end   (prog_end),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  // Synchronous program memory: data one cycle after the address.
  always @(posedge clk) begin
    prog_instr <= mem[prog_addr];
    prog_end   <= (int'(prog_addr) >= plen);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Monitor: every accepted output word must be the next one the model predicted.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0h expected no output", out_data);
      end else begin
        chk("out_data", {56'd0, out_data}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : out_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : in_drv
    int unsigned d;
    in_valid = 1'b0;
    in_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (in_ready && !in_valid) begin
        d = $urandom_range(in_dly_min, in_dly_max);
        repeat (d) begin @(posedge clk); #1; end
        if (in_ready) begin
          in_data  = (in_q.size() > 0) ? in_q.pop_front() : 8'h00;
          in_valid = 1'b1;
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
      end
    end
  end

  task automatic load_prog(input string s);
    plen = s.len();
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        ">": mem[i] = 3'd0;
        "<": mem[i] = 3'd1;
        "+": mem[i] = 3'd2;
        "-": mem[i] = 3'd3;
        ".": mem[i] = 3'd4;
        ",": mem[i] = 3'd5;
        "[": mem[i] = 3'd6;
        default: mem[i] = 3'd7;
      endcase
    end
  endtask

  // Reference interpreter; st: 0 done, 1..3 error code, 4 model gave up.
  task automatic model_run(output int st);
    int pc, ptr, idx, depth, q, steps;
    int stk [$];
    pc = 0; ptr = 0; idx = 0; st = -1; steps = 0;
    while (st < 0) begin
      steps++;
      if (steps > 50000) st = 4;
      else if (pc >= plen) st = 0;
      else begin
        case (mem[pc])
          3'd0: ptr = (ptr + 1) % 16;
          3'd1: ptr = (ptr + 15) % 16;
`ifdef BFPU_SATURATE_EN
          3'd2: if (m_tape[ptr] < 255) m_tape[ptr] = m_tape[ptr] + 1;
          3'd3: if (m_tape[ptr] > 0) m_tape[ptr] = m_tape[ptr] - 1;
`else
          3'd2: m_tape[ptr] = (m_tape[ptr] + 1) % 256;
          3'd3: m_tape[ptr] = (m_tape[ptr] + 255) % 256;
`endif
          3'd4: exp_q.push_back(8'(m_tape[ptr]));
          3'd5: begin
            m_tape[ptr] = (idx < in_q.size()) ? int'(in_q[idx]) : 0;
            idx++;
          end
          3'd6: begin
            if (m_tape[ptr] != 0) begin
              if (stk.size() == 8) st = 1;
              else stk.push_back(pc);
            end else begin
              depth = 1;
              q = pc;
              while (depth > 0 && st < 0) begin
                q++;
                if (q >= plen) st = 3;
                else if (mem[q] == 3'd6) depth++;
                else if (mem[q] == 3'd7) depth--;
              end
              pc = q;
            end
          end
          default: begin
            if (stk.size() == 0) st = 2;
            else if (m_tape[ptr] != 0) pc = stk[$];
            else void'(stk.pop_back());
          end
        endcase
        pc++;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0 normal, 1 output stall, 2 reset during OUT_WAIT, 3 start while busy.
  task automatic run_prog(input string nm, input string p, input int mode);
    int st;
    int cyc;
    load_prog(p);
    exp_q.delete();
    model_run(st);
    if (mode == 1 || mode == 2) hold_ready = 1'b1;
    pulse_start();
    chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
    if (mode == 3) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    if (mode == 1 || mode == 2) begin
      cyc = 0;
      while (!out_valid && cyc < 500) begin @(negedge clk); cyc++; end
      if (!out_valid) fail_now({nm, "_out_valid"});
      if (mode == 1) begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk({nm, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
          chk({nm, "_stall_data"}, {56'd0, out_data}, {56'd0, exp_q[0]});
        end
        hold_ready = 1'b0;
      end else begin
        chk({nm, "_pre_rst_data"}, {56'd0, out_data}, {56'd0, exp_q[0]});
        rst = 1'b1;
        @(negedge clk);
        chk({nm, "_rst_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({nm, "_rst_busy"}, {63'd0, busy}, 64'd1);
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_tape[i] = 0;
        rst = 1'b0;
        hold_ready = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin @(negedge clk); cyc++; end
        if (busy) fail_now({nm, "_clear"});
        return;
      end
    end
    cyc = 0;
    while (busy && cyc < 30000) begin @(negedge clk); cyc++; end
    if (busy) begin
      fail_now({nm, "_finish"});
      return;
    end
    chk({nm, "_done"}, {63'd0, done}, (st == 0) ? 64'd1 : 64'd0);
    chk({nm, "_error"}, {63'd0, error}, (st != 0) ? 64'd1 : 64'd0);
    chk({nm, "_err_code"}, {62'd0, err_code}, (st == 0) ? 64'd0 : 64'(st));
    chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    string toks [8];
    string p;
    int    cnt;
    int    n;
    toks = '{"+", "-", ">", "<", ".", ",", "[-]", "[>+<-]"};
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 3'd0;
    for (int i = 0; i < 16; i++) m_tape[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_err_code", {62'd0, err_code}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_prog_addr", {56'd0, prog_addr}, 64'd0);
    chk("rst_out_data", {56'd0, out_data}, 64'd0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin @(negedge clk); cnt++; end
    chk("clear_cycles", 64'(cnt), 64'd16);

    run_prog("inc3", "+++.", 0);
    run_prog("dec_wrap", "[-]-.", 0);
    in_q.delete(); in_q.push_back(8'hFF);
    run_prog("inc_top", ",+.", 0);
    run_prog("ptr_wrap", "<+.", 0);
    run_prog("loop_mul", "[-]>[-]<+++[>++<-]>.", 0);
    run_prog("skip_nest", "[-][[+]+].", 0);
    in_q.delete(); in_q.push_back(8'h41);
    in_dly_min = 5; in_dly_max = 5;
    run_prog("input", ",+.", 0);
    in_dly_min = 0; in_dly_max = 3;
    run_prog("stall", "[-]+++.", 1);
    run_prog("err_close", "]", 0);
    run_prog("err_open", "[-][", 0);
    run_prog("err_ovf", "[-]+[+[+[+[+[+[+[+[+[", 0);
    run_prog("after_err", "[-]+.", 0);
    run_prog("start_busy", "[-]>[-]<+++[>++<-]>.", 3);
    run_prog("mid_rst", "+++.", 2);
    run_prog("tape_zero", ".>.>>>.<<<<.", 0);
    run_prog("rerun", "+++.", 0);

    for (int r = 0; r < 12; r++) begin
      p = "";
      n = $urandom_range(6, 10);
      for (int k = 0; k < n; k++) p = {p, toks[$urandom_range(0, 7)]};
      in_q.delete();
      for (int k = 0; k < 4; k++) in_q.push_back(8'($urandom_range(0, 255)));
      run_prog("random", p, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bfpu_core.md
Name: bfpu_core

Overview:
- Parametrised Brainfuck execution core; the next-generation engine behind the TinyTapeout BFPU top.
- Fetches 3-bit opcodes from external synchronous program memory and holds the data tape internally.
- Loop handling uses a hardware bracket stack plus a forward-skip counter.
- Byte I/O uses valid/ready handshakes, so the top level can bridge it to pins or a UART.

Parameters:
CELL_WIDTH, 8, bits per tape cell and per I/O word
TAPE_DEPTH, 16, number of tape cells (power of two); PTR_WIDTH = $clog2(TAPE_DEPTH)
PC_WIDTH, 8, program address width
STACK_DEPTH, 8, maximum nesting depth of '[' return addresses

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins execution at pc=0 when IDLE or DONE
prog_addr  out  PC_WIDTH  program fetch address (registered)
prog_instr  in  3  opcode at prog_addr, valid one cycle after prog_addr changes
prog_end  in  1  qualifies prog_instr: no instruction at prog_addr (program end)
in_data  in  CELL_WIDTH  input word
in_valid  in  1  input word available
in_ready  out  1  core accepts input (high only in IN_WAIT)
out_data  out  CELL_WIDTH  output word, stable while out_valid
out_valid  out  1  output word pending
out_ready  in  1  consumer accepts output
busy  out  1  high in every state except IDLE, DONE and ERROR
done  out  1  high in DONE
error  out  1  high in ERROR
err_code  out  2  0 none, 1 stack overflow, 2 unmatched ']', 3 unmatched '[' (skip hit prog_end)

Behaviour:
- Opcodes (package): 0 '>', 1 '<', 2 '+', 3 '-', 4 '.', 5 ',', 6 '[', 7 ']'.
- States: CLEAR, IDLE, FETCH, EXEC, SKIP, OUT_WAIT, IN_WAIT, DONE, ERROR.
- Reset: state=CLEAR; pc=0, ptr=0, sp=0, skip_depth=0, clr_idx=0.
- Reset output values: all outputs 0 except busy=1.
- CLEAR: zeroes one cell per cycle (clr_idx 0..TAPE_DEPTH-1), then goes to IDLE. Start takes exactly TAPE_DEPTH cycles after rst deasserts.
- rst asserted in any state, including mid-handshake, restarts CLEAR and drops out_valid/in_ready the same edge.
- IDLE/DONE/ERROR: on start, clear pc, ptr, sp and err_code, then go to FETCH. The tape is NOT cleared on start.
- FETCH: drives prog_addr=pc for one cycle, then goes to EXEC.
- Cost: 2 cycles per non-I/O instruction.
- EXEC with prog_end=1: go to DONE.
- EXEC with prog_end=0, per opcode:
  - '>' / '<': ptr ±1 modulo TAPE_DEPTH (wraps both ways).
  - '+' / '-': cell ±1 modulo 2^CELL_WIDTH.
  - '.': latch out_data=cell, out_valid=1, go to OUT_WAIT.
  - ',': in_ready=1, go to IN_WAIT.
  - '[' with cell!=0: push pc; if sp==STACK_DEPTH, go to ERROR with code 1 and no push.
  - '[' with cell==0: skip_depth=1, go to SKIP.
  - ']' with sp==0: go to ERROR with code 2.
  - ']' with cell!=0: pc = stack[top]+1; the stack is unchanged.
  - ']' with cell==0: pop.
  - Every other case: pc+1, then back to FETCH.
- SKIP: fetch/decode loop at 2 cycles per instruction.
  - '[' increments skip_depth; ']' decrements it.
  - When skip_depth reaches 0, pc = that ']' address +1 and go to FETCH.
  - prog_end in SKIP goes to ERROR with code 3.
  - skip_depth is PC_WIDTH bits wide.
- OUT_WAIT: hold out_data/out_valid until out_valid&&out_ready, then clear out_valid, pc+1, go to FETCH.
- IN_WAIT: on in_valid&&in_ready, write cell=in_data and drop in_ready the same edge, then pc+1, go to FETCH.
- pc overflow past 2^PC_WIDTH-1 wraps to 0. The program must present prog_end.
- start while busy is ignored.

Optional Feature:
- Macro: BFPU_SATURATE_EN.
- Defined: '+' at all-ones and '-' at 0 leave the cell unchanged (saturating arithmetic).
- Undefined: modulo wrap as described above.
- Pointer wrap is unaffected in both cases.

Decomposition:
- Package bfpu_pkg holds:
  - opcode localparams OP_RIGHT..OP_LOOP_END;
  - state enum typedef;
  - err_code constants ERR_NONE, ERR_OVF, ERR_UNMATCHED_CLOSE, ERR_UNMATCHED_OPEN.
- One sub-module, bfpu_loop_stack (parameters STACK_DEPTH, PC_WIDTH):
  - signals push, pop, top, empty, full;
  - synchronous clear on rst or start.
- The tape stays a register array inside bfpu_core.

Test Plan:
- Reset: after rst, busy=1 for 16 cycles with TAPE_DEPTH=16; program "+++." then outputs out_data=0x03, then done=1.
- Wrap: "-." outputs 0xFF, or 0x00 with BFPU_SATURATE_EN; "<+." wraps ptr to 15 and outputs 0x01.
- Loops: "+++[>++<-]>." outputs 0x06; "[[+]+]." skips the nested loop and outputs 0x00.
- I/O handshakes: ",+." with in_valid delayed 5 cycles and in_data=0x41 outputs 0x42. Holding out_ready low for 10 cycles keeps out_valid=1 and out_data stable.
- Errors: "]" gives error=1, err_code=2; "[" on a zero cell gives err_code=3; nine nested "+[" gives err_code=1 with STACK_DEPTH=8.
- Mid-run reset: rst during OUT_WAIT drops out_valid the same edge, the tape reads back zero, and a subsequent start reruns cleanly.
